// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler:
//   - state_t      : scheduler FSM states (checksum states only when
//                    CHECKSUM_EN is defined)
//   - DEF_HDR_SYNC : default upper nibble of every packet header
//   - build_hdr()  : header byte = {sync nibble, requester id}
//   - calc_chk()   : checksum byte = header XOR payload
// Optional feature macro: CHECKSUM_EN
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam logic [3:0] DEF_HDR_SYNC = 4'hA;

    // Widest byte the checksum helper handles; callers cast down.
    localparam int CHK_MAX_W = 32;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_ACK_HDR,
        ST_DONE_HDR,
        ST_SEND_PAY,
        ST_ACK_PAY,
        ST_DONE_PAY
`ifdef CHECKSUM_EN
        ,
        ST_SEND_CHK,
        ST_ACK_CHK,
        ST_DONE_CHK
`endif
    } state_t;

    function automatic logic [7:0] build_hdr(input logic [3:0] sync,
                                             input logic [3:0] id);
        return {sync, id};
    endfunction

    function automatic logic [CHK_MAX_W-1:0] calc_chk(input logic [CHK_MAX_W-1:0] hdr,
                                                       input logic [CHK_MAX_W-1:0] pay);
        return hdr ^ pay;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set request at or after
// the pointer, wrapping at N_REQ.
// Ports:
//   req   in  N_REQ  request vector
//   ptr   in  ID_W   highest-priority index for this decision
//   grant out N_REQ  one-hot grant (all zero when no request)
//   id    out ID_W   encoded index of the grant
//   valid out 1      at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one baud-enabled UART transmitter among N_REQ byte producers.
// Requesters are granted round-robin; each grant becomes a packet of
// header byte {HDR_SYNC, id} then the latched payload byte (and, with
// CHECKSUM_EN defined, a checksum byte header^payload). Each byte is handed
// to the transmitter with a start pulse, then the scheduler waits for busy
// to rise (bounded by ACK_TIMEOUT) and fall before moving on.
// Optional feature macro: CHECKSUM_EN
// Ports:
//   i_clk       in  1             system clock
//   i_rst       in  1             asynchronous reset, active-low
//   i_req       in  N_REQ         request levels, held until acked
//   i_data      in  N_REQ*DATA_W  payloads, requester k at [k*DATA_W +: DATA_W]
//   o_ack       out N_REQ         one-cycle pulse: payload k latched
//   o_tx_start  out 1             one-cycle start pulse to the transmitter
//   o_tx_data   out DATA_W        byte to transmit, held until next start
//   i_tx_busy   in  1             transmitter busy level
//   o_active    out 1             packet in progress
//   o_err       out 1             sticky busy-timeout flag
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int         N_REQ       = 4,
    parameter int         DATA_W      = 8,
    parameter logic [3:0] HDR_SYNC    = DEF_HDR_SYNC,
    parameter int         ACK_TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*DATA_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_ack,
    output logic                    o_tx_start,
    output logic [DATA_W-1:0]       o_tx_data,
    input  logic                    i_tx_busy,
    output logic                    o_active,
    output logic                    o_err
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    // The counter starts at 0 on the first ACK cycle, so this value marks
    // the ACK_TIMEOUT-th cycle spent waiting for busy.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t             state;
    state_t             ack_next;
    state_t             done_next;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    id_q;
    logic [DATA_W-1:0]  pay_q;
    logic [CNT_W-1:0]   ack_cnt;

    logic [N_REQ-1:0]   arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               arb_valid;
    logic [DATA_W-1:0]  sel_data;
    logic [DATA_W-1:0]  hdr_byte;
    logic [ID_W-1:0]    ptr_next;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (i_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .id    (arb_id),
        .valid (arb_valid)
    );

    always_comb begin
        sel_data = i_data[int'(arb_id)*DATA_W +: DATA_W];
        hdr_byte = DATA_W'(build_hdr(HDR_SYNC, 4'(id_q)));
        ptr_next = (arb_id == ID_W'(N_REQ - 1)) ? '0 : arb_id + 1'b1;
    end

`ifdef CHECKSUM_EN
    logic [DATA_W-1:0] chk_byte;
    always_comb begin
        chk_byte = DATA_W'(calc_chk(CHK_MAX_W'(hdr_byte), CHK_MAX_W'(pay_q)));
    end
`endif

    // Successor states shared by the per-byte ACK and DONE handling.
    always_comb begin
        ack_next  = ST_DONE_HDR;
        done_next = ST_IDLE;
        case (state)
            ST_ACK_PAY:  ack_next = ST_DONE_PAY;
`ifdef CHECKSUM_EN
            ST_ACK_CHK:  ack_next = ST_DONE_CHK;
`endif
            default:     ack_next = ST_DONE_HDR;
        endcase
        case (state)
            ST_DONE_HDR: done_next = ST_SEND_PAY;
`ifdef CHECKSUM_EN
            ST_DONE_PAY: done_next = ST_SEND_CHK;
`endif
            default:     done_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            id_q       <= '0;
            pay_q      <= '0;
            ack_cnt    <= '0;
            o_ack      <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_active   <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_ack      <= '0;
            o_tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        id_q     <= arb_id;
                        pay_q    <= sel_data;
                        o_ack    <= arb_grant;
                        ptr      <= ptr_next;
                        o_active <= 1'b1;
                        state    <= ST_SEND_HDR;
                    end
                end
                ST_SEND_HDR: begin
                    o_tx_data  <= hdr_byte;
                    o_tx_start <= 1'b1;
                    ack_cnt    <= '0;
                    state      <= ST_ACK_HDR;
                end
                ST_SEND_PAY: begin
                    o_tx_data  <= pay_q;
                    o_tx_start <= 1'b1;
                    ack_cnt    <= '0;
                    state      <= ST_ACK_PAY;
                end
`ifdef CHECKSUM_EN
                ST_SEND_CHK: begin
                    o_tx_data  <= chk_byte;
                    o_tx_start <= 1'b1;
                    ack_cnt    <= '0;
                    state      <= ST_ACK_CHK;
                end
`endif
                ST_ACK_HDR, ST_ACK_PAY
`ifdef CHECKSUM_EN
                , ST_ACK_CHK
`endif
                : begin
                    if (i_tx_busy) begin
                        state <= ack_next;
                    end else if (ack_cnt == CNT_LAST) begin
                        // Transmitter never took the byte: drop the packet.
                        o_err    <= 1'b1;
                        o_active <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end
                ST_DONE_HDR, ST_DONE_PAY
`ifdef CHECKSUM_EN
                , ST_DONE_CHK
`endif
                : begin
                    if (!i_tx_busy) begin
                        state <= done_next;
                        if (done_next == ST_IDLE) begin
                            o_active <= 1'b0;
                        end
                    end
                end
                default: begin
                    o_active <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Directed bench for uart_tx_scheduler with a packet-level reference model
// (round-robin pick, expected byte queue, busy-timeout counting) compared
// against the DUT every cycle, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int N = 4;
    localparam int W = 8;
    localparam int T = 255;
`ifdef CHECKSUM_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N*W-1:0] data = '0;
    logic         busy  = 1'b0;
    logic [N-1:0] ack;
    logic         start;
    logic [W-1:0] txd;
    logic         active;
    logic         err;

    always #5 clk = ~clk;

    uart_tx_scheduler #(
        .N_REQ       (N),
        .DATA_W      (W),
        .HDR_SYNC    (4'hA),
        .ACK_TIMEOUT (T)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_req      (req),
        .i_data     (data),
        .o_ack      (ack),
        .o_tx_start (start),
        .o_tx_data  (txd),
        .i_tx_busy  (busy),
        .o_active   (active),
        .o_err      (err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transmitter stand-in: busy rises 3 cycles after a start, lasts 10 cycles.
    logic tx_respond = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (start && tx_respond) begin
                repeat (3) @(posedge clk);
                #1 busy = 1'b1;
                repeat (10) @(posedge clk);
                #1 busy = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [N-1:0] exp_ack    = '0;
    logic         exp_err    = 1'b0;
    logic         exp_active = 1'b0;
    logic         awaiting   = 1'b0;
    logic         in_byte    = 1'b0;
    int           waitcnt    = 0;
    int           m_ptr      = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_data  = '0;
    logic [W-1:0] seen[$];

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    initial begin
        logic         nxt_active;
        int           g;
        logic [W-1:0] h;
        logic [W-1:0] pl;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_ack", ack, 0);
                chk("rst_start", start, 0);
                chk("rst_data", txd, 0);
                chk("rst_active", active, 0);
                chk("rst_err", err, 0);
                exp_ack = '0; exp_err = 1'b0; exp_active = 1'b0;
                awaiting = 1'b0; in_byte = 1'b0; waitcnt = 0; m_ptr = 0;
                exp_q.delete(); last_data = '0;
            end else begin
                chk("ack", ack, exp_ack);
                chk("err", err, exp_err);
                chk("active", active, exp_active);
                if (start) begin
                    seen.push_back(txd);
                    if (exp_q.size() == 0) chk("unexp_start", start, 0);
                    else chk("byte", txd, exp_q.pop_front());
                    last_data = txd;
                    awaiting  = 1'b1;
                    waitcnt   = 0;
                end else begin
                    chk("hold", txd, last_data);
                end
                nxt_active = exp_active;
                exp_ack    = '0;
                if (awaiting) begin
                    if (busy) begin
                        awaiting = 1'b0;
                        in_byte  = 1'b1;
                    end else begin
                        waitcnt++;
                        if (waitcnt == T) begin
                            awaiting   = 1'b0;
                            exp_err    = 1'b1;
                            nxt_active = 1'b0;
                            exp_q.delete();
                        end
                    end
                end else if (in_byte && !busy) begin
                    in_byte = 1'b0;
                    if (exp_q.size() == 0) nxt_active = 1'b0;
                end
                if (!exp_active && req != '0) begin
                    g       = pick(req, m_ptr);
                    exp_ack = N'(1) << g;
                    m_ptr   = (g + 1) % N;
                    h       = {4'hA, 4'(g)};
                    pl      = data[g*W +: W];
                    exp_q.push_back(h);
                    exp_q.push_back(pl);
`ifdef CHECKSUM_EN
                    exp_q.push_back(h ^ pl);
`endif
                    nxt_active = 1'b1;
                end
                exp_active = nxt_active;
            end
        end
    end

    // ---------------- flow helpers ----------------
    task automatic wait_ack(output logic [N-1:0] g);
        g = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (ack != '0) begin
                g = ack;
                break;
            end
        end
        if (g == '0) chk("wait_ack_timeout", ack, 1);
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (!active && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("wait_done_timeout", active, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [N-1:0] g;
        int           cnt;
        logic [N-1:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack", ack, 0);
        chk("reset_data", txd, 0);
        chk("reset_active", active, 0);
        chk("reset_err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single request: id 2, payload 5C
        data = 32'h005C_0000;
        seen.delete();
        req = 4'b0100;
        wait_ack(g);
        chk("t1_ack", g, 4'b0100);
        @(posedge clk); #1 req = '0;
        wait_done();
        chk("t1_nbytes", seen.size(), NB);
        chk("t1_hdr", seen[0], 8'hA2);
        chk("t1_pay", seen[1], 8'h5C);
`ifdef CHECKSUM_EN
        chk("t1_chk", seen[2], 8'hFE);
`endif
        chk("t1_active", active, 0);

        // Wrap: pointer now 3, requests 3 and 0
        @(posedge clk); #1;
        data = 32'h1122_3344;
        seen.delete();
        req = 4'b1001;
        wait_ack(g);
        chk("wrap_first", g, 4'b1000);
        wait_done();
        wait_ack(g);
        chk("wrap_second", g, 4'b0001);
        @(posedge clk); #1 req = '0;
        wait_done();
        chk("wrap_hdr0", seen[0], 8'hA3);
        chk("wrap_pay0", seen[1], 8'h11);
        chk("wrap_hdr1", seen[NB], 8'hA0);
        chk("wrap_pay1", seen[NB+1], 8'h44);

        // Timeout: transmitter never raises busy
        @(posedge clk); #1;
        tx_respond = 1'b0;
        data = 32'h0000_9900;
        seen.delete();
        req = 4'b0010;
        wait_ack(g);
        chk("to_ack", g, 4'b0010);
        @(posedge clk); #1 req = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (start) break;
        end
        cnt = 0;
        while (!err && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("to_latency", cnt, T);
        chk("to_active", active, 0);
        repeat (3) @(negedge clk);
        chk("to_nbytes", seen.size(), 1);
        chk("to_hdr", seen[0], 8'hA1);
        @(posedge clk); #1;
        tx_respond = 1'b1;
        data = 32'h0000_0042;
        seen.delete();
        req = 4'b0001;
        wait_ack(g);
        chk("after_to_ack", g, 4'b0001);
        @(posedge clk); #1 req = '0;
        wait_done();
        chk("after_to_pay", seen[1], 8'h42);
        chk("after_to_err", err, 1);

        // Reset while waiting for the payload byte to finish
        @(posedge clk); #1;
        data = 32'h0077_0000;
        seen.delete();
        req = 4'b0100;
        wait_ack(g);
        @(posedge clk); #1 req = '0;
        for (int n = 0; n < 200 && seen.size() < 2; n++) @(negedge clk);
        for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("pre_rst_active", active, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ack", ack, 0);
        chk("midrst_start", start, 0);
        chk("midrst_data", txd, 0);
        chk("midrst_active", active, 0);
        chk("midrst_err", err, 0);
        @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        for (int n = 0; n < 30 && busy; n++) @(negedge clk);
        @(posedge clk); #1;

        // Round-robin from reset pointer 0
        data = 32'h4433_2211;
        seen.delete();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(g);
            chk($sformatf("rr_grant%0d", i), g, rr_exp[i]);
            if (i == 4) begin
                @(posedge clk); #1 req = '0;
            end
            wait_done();
        end
        chk("rr_pay_last", seen[4*NB+1], 8'h11);

        // Id 1, payload 3F (checksum 9E when enabled)
        @(posedge clk); #1;
        data = 32'h0000_3F00;
        seen.delete();
        req = 4'b0010;
        wait_ack(g);
        chk("ck_ack", g, 4'b0010);
        @(posedge clk); #1 req = '0;
        wait_done();
        chk("ck_nbytes", seen.size(), NB);
        chk("ck_hdr", seen[0], 8'hA1);
        chk("ck_pay", seen[1], 8'h3F);
`ifdef CHECKSUM_EN
        chk("ck_chk", seen[2], 8'h9E);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter among N_REQ byte producers, for example the redstone output snapshot, the switch readback and a status reporter. It grants requesters round-robin and frames each grant as a packet: header byte, then payload byte. It sequences the transmitter through a start/busy handshake. It sits between the producers and uart_transmit, in the same clock domain; the transmitter is baud-enabled rather than separately clocked.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 8, payload and UART byte width
HDR_SYNC, 4'hA, upper nibble of the header byte
ACK_TIMEOUT, 255, max cycles from o_tx_start to i_tx_busy rising before abort

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-low
i_req  in  N_REQ  per-requester request level; held until acked
i_data  in  N_REQ*DATA_W  payloads, requester k at bits [k*DATA_W +: DATA_W]
o_ack  out  N_REQ  one-cycle pulse: payload of requester k latched, k may drop req
o_tx_start  out  1  one-cycle pulse to transmitter
o_tx_data  out  DATA_W  byte to transmit, stable from start until busy falls
i_tx_busy  in  1  transmitter busy level
o_active  out  1  packet in progress
o_err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (async, i_rst=0): state IDLE; RR pointer=0; o_ack=0, o_tx_start=0, o_tx_data=0, o_active=0, o_err=0.
- States: IDLE, SEND_HDR, ACK_HDR, DONE_HDR, SEND_PAY, ACK_PAY, DONE_PAY; with CHECKSUM_EN also SEND_CHK, ACK_CHK, DONE_CHK.
- IDLE: if any i_req, grant the first set bit at or after the pointer, wrapping at N_REQ.
  - Same cycle: latch id and payload, pulse o_ack[id] for exactly 1 cycle, set pointer=(id+1) mod N_REQ, go to SEND_HDR.
  - Grant decision to o_ack is 1 cycle.
- SEND_x: drive o_tx_data, pulse o_tx_start for 1 cycle, go to ACK_x.
- ACK_x: wait for i_tx_busy=1, then go to DONE_x.
  - Count cycles; if the counter reaches ACK_TIMEOUT, set o_err, drop the packet and go to IDLE.
- DONE_x: wait for i_tx_busy=0, then advance HDR -> PAY (-> CHK) -> IDLE.
- Header byte = {HDR_SYNC, id zero-extended to 4 bits}. Payload = latched i_data slice.
- o_tx_data holds its value until the next SEND. o_active=1 in every state except IDLE.
- Busy already high when SEND_x is entered: the start pulse is still issued; ACK_x completes next cycle.
- Requests that change during a packet are ignored until return to IDLE. Back-to-back packets need at least one IDLE cycle between them.
- A request dropped before ack is never sent.
- Reset mid-packet aborts immediately; the transmitter's own reset finishes its byte.

Optional Feature:
CHECKSUM_EN
- Defined: a third byte = header XOR payload follows the payload, using SEND_CHK/ACK_CHK/DONE_CHK.
- Undefined: packets are 2 bytes and the CHK states do not exist.

Decomposition:
- Shared package uart_pkg holds:
  - State enum.
  - HDR_SYNC default.
  - Header build function.
  - Checksum function.
- One sub-module, rr_arbiter (N_REQ): request vector and pointer in; one-hot grant and encoded id out; purely combinational.

Test Plan:
- Single request: i_req=4'b0100, data[2]=8'h5C, model busy high 3 cycles after start, 10 cycles long -> o_ack[2] pulse; bytes 8'hA2 then 8'h5C; o_active falls after the second busy fall.
- Round-robin: all four requesting continuously, ack re-raises req -> grant order 0,1,2,3,0; no requester granted twice before others.
- Wrap: pointer=3, i_req=4'b1001 -> grants 3 then 0.
- Timeout: busy held 0 after start -> o_err=1 at ACK_TIMEOUT cycles, state IDLE, no payload start, next request still serviced.
- Reset during DONE_PAY -> all outputs 0 at once; o_err cleared; pointer 0.
- CHECKSUM_EN: id 1, data 8'h3F -> bytes 8'hA1, 8'h3F, 8'h9E.
